// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full_adder cell is reused over WIDTH cycles,
// LSB first, with a registered carry between bit positions.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic carry,
    output logic sum
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry_q),
        .carry (fa_carry),
        .sum   (fa_sum)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction becomes a + ~b + 1: invert B, force carry-in.
                        a_sh    <= op_a;
                        b_sh    <= sub ? ~op_b : op_b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    r_sh    <= {fa_sum, r_sh[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    if (cnt == LAST) begin
                        // Last bit: publish the completed result, including this cycle's bit.
                        sum   <= {fa_sum, r_sh[WIDTH-1:1]};
                        cout  <= fa_carry;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 directed cases and a WIDTH=4 exhaustive
// sweep, both checked every cycle against a timeline/arithmetic model.

module tb_serial_add_ctrl;
    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [W8-1:0] a8 = '0, b8 = '0;
    logic          busy8, done8, cout8;
    logic [W8-1:0] sum8;

    logic          start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
    logic [W4-1:0] a4 = '0, b4 = '0;
    logic          busy4, done4, cout4;
    logic [W4-1:0] sum4;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int dn4 = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4),
        .cin(cin4), .sub(sub4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: ph = cycles since an accepted start (0 = idle); the result is
    // plain (WIDTH+1)-bit arithmetic, published when the timeline reaches done.
    int          ph8 = 0, ph4 = 0;
    logic [W8:0] pend8 = '0, res8 = '0;
    logic [W4:0] pend4 = '0, res4 = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph8 <= 0; res8 <= '0;
        end else if (ph8 == 0) begin
            if (start8) begin
                ph8   <= 1;
                pend8 <= sub8 ? ({1'b0, a8} + {1'b0, ~b8} + 9'd1)
                              : ({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
            end
        end else if (ph8 == W8 + 1) begin
            ph8 <= 0;
        end else begin
            if (ph8 == W8) res8 <= pend8;
            ph8 <= ph8 + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            ph4 <= 0; res4 <= '0;
        end else if (ph4 == 0) begin
            if (start4) begin
                ph4   <= 1;
                pend4 <= sub4 ? ({1'b0, a4} + {1'b0, ~b4} + 5'd1)
                              : ({1'b0, a4} + {1'b0, b4} + {4'd0, cin4});
            end
        end else if (ph4 == W4 + 1) begin
            ph4 <= 0;
        end else begin
            if (ph4 == W4) res4 <= pend4;
            ph4 <= ph4 + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8", busy8, (ph8 >= 1 && ph8 <= W8));
            chk("done8", done8, (ph8 == W8 + 1));
            chk("sum8",  sum8,  res8[W8-1:0]);
            chk("cout8", cout8, res8[W8]);
            chk("busy4", busy4, (ph4 >= 1 && ph4 <= W4));
            chk("done4", done4, (ph4 == W4 + 1));
            chk("sum4",  sum4,  res4[W4-1:0]);
            chk("cout4", cout4, res4[W4]);
            if (done4) dn4++;
        end
    end

    task automatic wait_idle8();
        int k = 0;
        @(negedge clk);
        while ((busy8 || done8) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) chk("idle8_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                          input logic c, input logic s);
        wait_idle8();
        a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c; sub8 = ~s;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) chk("done8_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect8(input string nm, input logic [W8-1:0] s, input logic c);
        int lat;
        wait_done8(lat);
        chk({nm, "_lat"},  lat,   W8);
        chk({nm, "_sum"},  sum8,  s);
        chk({nm, "_cout"}, cout8, c);
    endtask

    task automatic run4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                        input logic c, input logic s, input logic [W4:0] exp);
        int k = 0;
        bit seen = 1'b0;
        @(negedge clk);
        while ((busy4 || done4) && k < 30) begin
            @(negedge clk);
            k++;
        end
        a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done4_timeout", 32'd1, 32'd0);
        else chk(s ? "sub4_result" : "add4_result", {cout4, sum4}, exp);
    endtask

    initial begin
        int lat;
        int busy_wait;
        int nops;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_sum",  sum8,  8'h00);
        chk("rst_cout", cout8, 1'b0);
        rst_n = 1'b1;

        issue8(8'h3C, 8'h05, 1'b0, 1'b0); expect8("add_3c_05", 8'h41, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 1'b0); expect8("add_ff_01", 8'h00, 1'b1);
        issue8(8'hFF, 8'hFF, 1'b1, 1'b0); expect8("add_ff_ff_1", 8'hFF, 1'b1);
        issue8(8'h10, 8'h01, 1'b0, 1'b1); expect8("sub_10_01", 8'h0F, 1'b1);
        issue8(8'h01, 8'h02, 1'b1, 1'b1); expect8("sub_01_02", 8'hFF, 1'b0);

        // Start held high with new operands through RUN and DONE: only the
        // first IDLE after done may take it.
        wait_idle8();
        a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55;
        expect8("ignored_start", 8'h41, 1'b0);
        busy_wait = 0;
        while (!busy8 && busy_wait < 10) begin
            @(negedge clk);
            busy_wait++;
        end
        chk("reaccept_gap", busy_wait, 2);
        start8 = 1'b0;
        expect8("add_aa_55", 8'hFF, 1'b0);

        // Reset sampled at the 4th RUN edge aborts the operation.
        issue8(8'h3C, 8'h05, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy8, 1'b0);
        chk("abort_done", done8, 1'b0);
        chk("abort_sum",  sum8,  8'h00);
        chk("abort_cout", cout8, 1'b0);
        rst_n = 1'b1;
        issue8(8'h3C, 8'h05, 1'b0, 1'b0); expect8("after_abort", 8'h41, 1'b0);

        dn4 = 0;
        nops = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    run4(4'(a), 4'(b), c[0], 1'b0, 5'(a + b + c));
                    nops++;
                end
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b), 1'b1, 1'b1, {(a >= b), 4'(a - b)});
                nops++;
            end
        @(negedge clk);
        chk("done4_count", dn4, nops);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
